// File: rtl/hydra_pkg.sv
// hydra_pkg -- types and constants shared by hydra write-port logic.
//   hdr_t        : packet header word {len, prio, dest}
//   fill_state_t : ingress buffer fill FSM states
//   send_state_t : hydra write-side emit FSM states
package hydra_pkg;

  localparam int DATA_W   = 16;
  localparam int LEN_W    = 9;
  localparam int PORT_NUM = 16;

  typedef struct packed {
    logic [8:0] len;
    logic [2:0] prio;
    logic [3:0] dest;
  } hdr_t;

  typedef enum logic [1:0] {FILL, DISCARD, HOLD} fill_state_t;

  typedef enum logic [2:0] {IDLE, SOP, HDR, DATA, EOP} send_state_t;

endpackage

// File: rtl/framer_buf.sv
// framer_buf -- single-write / single-read synchronous packet RAM.
//   clk      : clock
//   wr_en    : write strobe, wr_data stored at wr_addr
//   rd_en    : read strobe, ram[rd_addr] appears on rd_data next cycle
//   rd_data  : registered read data (holds while rd_en is low)
// Contents are never reset so the array maps onto block RAM.
module framer_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

endmodule

// File: rtl/port_tx_framer.sv
// port_tx_framer -- store-and-forward ingress framer for one hydra write port.
// A whole packet is buffered from the client valid/ready stream, then sent as
// sop cycle, header word, len data words, eop cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : client handshake; in_data/in_last payload
//   in_dest/in_prio     : sampled with the first word of a packet
//   pause               : hydra back-pressure, only honoured before sop
//   wr_sop/vld/eop/data : hydra write protocol
//   drop                : one-cycle pulse when an oversize packet is discarded
// Optional macro FRAMER_STATS_EN adds pkt_cnt / drop_cnt 16-bit counters.
module port_tx_framer
  import hydra_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MAX_LEN = 128,
  parameter int LEN_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [3:0]        in_dest,
  input  logic [2:0]        in_prio,
  input  logic              pause,
  output logic              wr_sop,
  output logic              wr_vld,
  output logic              wr_eop,
  output logic [DATA_W-1:0] wr_data,
  output logic              drop
`ifdef FRAMER_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int AW = $clog2(MAX_LEN);

  fill_state_t fill_state_reg, fill_state_next;
  send_state_t send_state_reg, send_state_next;

  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  idx_reg, idx_next;
  logic [3:0]        dest_reg;
  logic [2:0]        prio_reg;
  logic              drop_reg, drop_next;
  logic [DATA_W-1:0] hold_reg;

  logic              accept;
  logic              buf_full;
  logic              buf_we;
  logic              fill_to_hold;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  hdr_t              hdr;

  assign in_ready = (fill_state_reg != HOLD);
  assign accept   = in_valid & in_ready;
  assign buf_full = (cnt_reg == LEN_W'(MAX_LEN));
  assign drop     = drop_reg;

  // The last word landing this cycle lets the send side leave IDLE on the
  // same edge, so sop follows the last accepted word by one cycle.
  assign fill_to_hold = (fill_state_reg == FILL) && accept && in_last && !buf_full;

  framer_buf #(.DATA_W(DATA_W), .DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (cnt_reg[AW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Fill FSM
  always_comb begin
    fill_state_next = fill_state_reg;
    cnt_next        = cnt_reg;
    len_next        = len_reg;
    drop_next       = 1'b0;
    buf_we          = 1'b0;
    case (fill_state_reg)
      FILL: begin
        if (accept) begin
          if (buf_full) begin
            // Overflowing word is never written; a last word drops at once.
            if (in_last) begin
              drop_next = 1'b1;
              cnt_next  = '0;
            end else begin
              fill_state_next = DISCARD;
            end
          end else begin
            buf_we   = 1'b1;
            cnt_next = cnt_reg + LEN_W'(1);
            if (in_last) begin
              len_next        = cnt_reg + LEN_W'(1);
              fill_state_next = HOLD;
            end
          end
        end
      end
      DISCARD: begin
        if (accept && in_last) begin
          drop_next       = 1'b1;
          cnt_next        = '0;
          fill_state_next = FILL;
        end
      end
      HOLD: begin
        if (send_state_reg == EOP) begin
          cnt_next        = '0;
          fill_state_next = FILL;
        end
      end
      default: fill_state_next = FILL;
    endcase
  end

  // Send FSM and hydra outputs
  always_comb begin
    send_state_next = send_state_reg;
    idx_next        = idx_reg;
    rd_en           = 1'b0;
    rd_addr         = '0;
    hdr.len         = len_reg;
    hdr.prio        = prio_reg;
    hdr.dest        = dest_reg;
    wr_sop          = 1'b0;
    wr_vld          = 1'b0;
    wr_eop          = 1'b0;
    wr_data         = hold_reg;
    case (send_state_reg)
      IDLE: begin
        if (!pause && ((fill_state_reg == HOLD) || fill_to_hold))
          send_state_next = SOP;
      end
      SOP: begin
        wr_sop          = 1'b1;
        send_state_next = HDR;
      end
      HDR: begin
        wr_vld          = 1'b1;
        wr_data         = DATA_W'(hdr);
        rd_en           = 1'b1;
        idx_next        = '0;
        send_state_next = DATA;
      end
      DATA: begin
        // RAM output is word idx; prefetch idx+1 for the next cycle.
        wr_vld   = 1'b1;
        wr_data  = rd_data;
        rd_en    = 1'b1;
        rd_addr  = AW'(idx_reg + LEN_W'(1));
        idx_next = idx_reg + LEN_W'(1);
        if (idx_reg == len_reg - LEN_W'(1))
          send_state_next = EOP;
      end
      EOP: begin
        wr_eop          = 1'b1;
        send_state_next = IDLE;
      end
      default: send_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_state_reg <= FILL;
      send_state_reg <= IDLE;
      cnt_reg        <= '0;
      len_reg        <= '0;
      idx_reg        <= '0;
      dest_reg       <= '0;
      prio_reg       <= '0;
      drop_reg       <= 1'b0;
      hold_reg       <= '0;
    end else begin
      fill_state_reg <= fill_state_next;
      send_state_reg <= send_state_next;
      cnt_reg        <= cnt_next;
      len_reg        <= len_next;
      idx_reg        <= idx_next;
      drop_reg       <= drop_next;
      hold_reg       <= wr_data;
      if (fill_state_reg == FILL && accept && cnt_reg == '0) begin
        dest_reg <= in_dest;
        prio_reg <= in_prio;
      end
    end
  end

`ifdef FRAMER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_eop)   pkt_cnt  <= pkt_cnt + 16'd1;
      if (drop_reg) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_port_tx_framer.sv
module tb_port_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [3:0]  in_dest;
  logic [2:0]  in_prio;
  logic        pause;
  logic        wr_sop;
  logic        wr_vld;
  logic        wr_eop;
  logic [15:0] wr_data;
  logic        drop;
`ifdef FRAMER_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  port_tx_framer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_dest  (in_dest),
    .in_prio  (in_prio),
    .pause    (pause),
    .wr_sop   (wr_sop),
    .wr_vld   (wr_vld),
    .wr_eop   (wr_eop),
    .wr_data  (wr_data),
    .drop     (drop)
`ifdef FRAMER_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected wr_vld words and expected packet lengths.
  logic [15:0] exp_q[$];
  int          len_q[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int sop_count = 0, eop_count = 0, drop_count = 0;
  int last_sop_cyc = -1, last_eop_cyc = -1, last_drop_cyc = -1;
  bit in_pkt = 0;
  int vld_cnt = 0, ready_viol = 0;

  always @(negedge clk) begin
    logic [15:0] exp_w;
    int          l;
    if (!rst_n) begin
      in_pkt = 0;
    end else begin
      if (wr_sop) begin
        sop_count++;
        last_sop_cyc = cyc;
        in_pkt = 1;
        vld_cnt = 0;
        ready_viol = 0;
      end
      if (in_pkt && in_ready) ready_viol++;
      if (wr_vld) begin
        if (exp_q.size() == 0) check("unexp_vld", 32'(wr_vld), 32'd0);
        else begin
          exp_w = exp_q.pop_front();
          check("word", 32'(wr_data), 32'(exp_w));
        end
        if (in_pkt) vld_cnt++;
      end
      if (drop) begin
        drop_count++;
        last_drop_cyc = cyc;
        $display("drop at cycle %0d", cyc);
      end
      if (wr_eop) begin
        eop_count++;
        last_eop_cyc = cyc;
        if (!in_pkt || len_q.size() == 0) check("orphan_eop", 32'd1, 32'd0);
        else begin
          l = len_q.pop_front();
          check("pkt_vld_cycles", 32'(vld_cnt), 32'(l + 1));
          check("ready_low_in_pkt", 32'(ready_viol), 32'd0);
          $display("packet len=%0d sop=%0d eop=%0d", l, last_sop_cyc, cyc);
        end
        in_pkt = 0;
      end
    end
  end

  int last_acc = 0;

  task automatic drive_pkt(input int n, input logic [3:0] dest, input logic [2:0] prio,
                           input logic [15:0] base);
    int waitc;
    if (n <= 128) begin
      exp_q.push_back({9'(n), prio, dest});
      for (int i = 0; i < n; i++) exp_q.push_back(base + 16'(i));
      len_q.push_back(n);
    end
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      in_last  = (i == n - 1);
      in_dest  = dest;
      in_prio  = prio;
      waitc    = 0;
      while (!in_ready && waitc < 2000) begin
        @(negedge clk);
        waitc++;
      end
      if (!in_ready) begin
        check("ready_timeout", 32'd0, 32'd1);
        break;
      end
      if (i == n - 1) last_acc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_eops(input int target);
    int w = 0;
    while (eop_count < target && w < 1000) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("eop_wait", 32'(eop_count >= target), 32'd1);
  endtask

  task automatic wait_sop(input int prev);
    int w = 0;
    while (sop_count == prev && w < 1000) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("sop_wait", 32'(sop_count > prev), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s0, d0, e0, p;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_dest = '0; in_prio = '0; pause = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_sop", 32'(wr_sop), 32'd0);
    check("rst_wr_vld", 32'(wr_vld), 32'd0);
    check("rst_wr_eop", 32'(wr_eop), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 31-word packet, latency
    drive_pkt(31, 4'd3, 3'd4, 16'd0);
    t = last_acc;
    wait_eops(1);
    check("p1_sop_latency", 32'(last_sop_cyc), 32'(t + 1));
    check("p1_eop_latency", 32'(last_eop_cyc), 32'(t + 34));

    // 56 words right behind it
    drive_pkt(56, 4'd3, 3'd3, 16'd100);
    t = last_acc;
    wait_eops(2);
    check("p2_eop_latency", 32'(last_eop_cyc), 32'(t + 3 + 56));

    // 128-word boundary packet
    d0 = drop_count;
    drive_pkt(128, 4'd3, 3'd5, 16'd1000);
    wait_eops(3);
    check("p3_no_drop", 32'(drop_count), 32'(d0));

    // 129 words: overflowing word is the last one
    s0 = sop_count;
    drive_pkt(129, 4'd3, 3'd1, 16'd2000);
    t = last_acc;
    repeat (4) @(negedge clk);
    #1;
    check("p4_drop_cycle", 32'(last_drop_cyc), 32'(t + 1));
    check("p4_drop_count", 32'(drop_count), 32'(d0 + 1));
    check("p4_no_sop", 32'(sop_count), 32'(s0));
    drive_pkt(1, 4'd3, 3'd0, 16'hBEEF);
    wait_eops(4);

    // 135 words: overflow goes through the discard path
    s0 = sop_count;
    drive_pkt(135, 4'd5, 3'd2, 16'd3000);
    t = last_acc;
    repeat (4) @(negedge clk);
    #1;
    check("p4b_drop_cycle", 32'(last_drop_cyc), 32'(t + 1));
    check("p4b_drop_count", 32'(drop_count), 32'(d0 + 2));
    check("p4b_no_sop", 32'(sop_count), 32'(s0));
    drive_pkt(2, 4'd6, 3'd7, 16'h4000);
    wait_eops(5);

    // pause held while packet waits; pause in HDR does not stall
    pause = 1'b1;
    s0 = sop_count;
    drive_pkt(5, 4'd7, 3'd2, 16'h5000);
    repeat (20) @(negedge clk);
    #1;
    check("p5_paused_no_sop", 32'(sop_count), 32'(s0));
    pause = 1'b0;
    p = cyc;
    wait_sop(s0);
    check("p5_sop_after_pause", 32'(last_sop_cyc), 32'(p + 1));
    @(negedge clk);
    pause = 1'b1;
    wait_eops(6);
    check("p5_eop_unstalled", 32'(last_eop_cyc), 32'(last_sop_cyc + 2 + 5));
    pause = 1'b0;

`ifdef FRAMER_STATS_EN
    check("stats_pkt_cnt", 32'(pkt_cnt), 32'(eop_count));
    check("stats_drop_cnt", 32'(drop_cnt), 32'(drop_count));
`endif

    // reset in the middle of DATA
    s0 = sop_count;
    drive_pkt(20, 4'd3, 3'd6, 16'h6000);
    wait_sop(s0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_wr_sop", 32'(wr_sop), 32'd0);
    check("mid_rst_wr_vld", 32'(wr_vld), 32'd0);
    check("mid_rst_wr_eop", 32'(wr_eop), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FRAMER_STATS_EN
    check("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    exp_q.delete();
    len_q.delete();
    e0 = eop_count;
    repeat (10) @(negedge clk);
    #1;
    check("no_trailing_eop", 32'(eop_count), 32'(e0));
    drive_pkt(3, 4'd9, 3'd7, 16'h7000);
    wait_eops(e0 + 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
